// File: rtl/dot_product_pkg.sv
// Shared defaults, FSM state type, complex word type and saturation helper
// for the dot_product correlation engine.
package dot_product_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int LANES          = 4;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cword_t;

  // Clamp a sign-extended value into the signed w-bit range (w <= 63).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dot_product_cmac_conj.sv
// Complex conjugate multiply-accumulate: acc += x * conj(m), with synchronous
// clear and a Q1.(WIDTH-1) saturated view of the accumulator.
module cmac_conj
  import dot_product_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] xRe_i,
  input  logic signed [WIDTH-1:0] xIm_i,
  input  logic signed [WIDTH-1:0] mRe_i,
  input  logic signed [WIDTH-1:0] mIm_i,
  output logic signed [WIDTH-1:0] resRe_o,
  output logic signed [WIDTH-1:0] resIm_o
);

  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = 2 * WIDTH + 3;

  logic signed [PW-1:0]   pRR, pII, pIR, pRI;
  logic signed [ACCW-1:0] accRe_q, accRe_d, accIm_q, accIm_d;
  logic signed [63:0]     shRe, shIm, satRe, satIm;
  logic                   unusedSatBits;

  assign pRR = PW'(xRe_i) * PW'(mRe_i);
  assign pII = PW'(xIm_i) * PW'(mIm_i);
  assign pIR = PW'(xIm_i) * PW'(mRe_i);
  assign pRI = PW'(xRe_i) * PW'(mIm_i);

  always_comb begin
    accRe_d = accRe_q;
    accIm_d = accIm_q;
    if (clr_i) begin
      accRe_d = '0;
      accIm_d = '0;
    end else if (en_i) begin
      accRe_d = accRe_q + ACCW'(pRR) + ACCW'(pII);
      accIm_d = accIm_q + ACCW'(pIR) - ACCW'(pRI);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accRe_q <= '0;
      accIm_q <= '0;
    end else begin
      accRe_q <= accRe_d;
      accIm_q <= accIm_d;
    end
  end

  // Drop the fractional half of the Q2.30 sum (floor), then clamp.
  assign shRe  = 64'(accRe_q >>> (WIDTH - 1));
  assign shIm  = 64'(accIm_q >>> (WIDTH - 1));
  assign satRe = saturate(shRe, WIDTH);
  assign satIm = saturate(shIm, WIDTH);

  assign resRe_o = satRe[WIDTH-1:0];
  assign resIm_o = satIm[WIDTH-1:0];
  assign unusedSatBits = ^{satRe[63:WIDTH], satIm[63:WIDTH]};

endmodule

// File: rtl/dot_product.sv
// Correlates a 4-lane complex vector against three history slots and itself,
// then appends the vector to an 8-deep history ring.
module dot_product
  import dot_product_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      inaReal,
  input  logic [WIDTH-1:0]      inaImag,
  input  logic [WIDTH-1:0]      inbReal,
  input  logic [WIDTH-1:0]      inbImag,
  input  logic [WIDTH-1:0]      incReal,
  input  logic [WIDTH-1:0]      incImag,
  input  logic [WIDTH-1:0]      indReal,
  input  logic [WIDTH-1:0]      indImag,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [ADDR_WIDTH-1:0] readAddrReal,
  input  logic [ADDR_WIDTH-1:0] readAddrImag,
  output logic [WIDTH-1:0]      outaReal,
  output logic [WIDTH-1:0]      outaImag,
  output logic [WIDTH-1:0]      outbReal,
  output logic [WIDTH-1:0]      outbImag,
  output logic [WIDTH-1:0]      outcReal,
  output logic [WIDTH-1:0]      outcImag,
  output logic [WIDTH-1:0]      outdReal,
  output logic [WIDTH-1:0]      outdImag,
  output logic                  done
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int NUM_REF = 3;
  localparam int NUM_MAC = NUM_REF + 1;
  localparam int LANE_W  = $clog2(LANES);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                latch, accEn, commit;

  logic [WIDTH-1:0]      inRe    [LANES];
  logic [WIDTH-1:0]      inIm    [LANES];
  logic [WIDTH-1:0]      xRe_q   [LANES];
  logic [WIDTH-1:0]      xIm_q   [LANES];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_REF];
  logic [WIDTH-1:0]      memRe_q [DEPTH][LANES];
  logic [WIDTH-1:0]      memIm_q [DEPTH][LANES];
  logic [ADDR_WIDTH-1:0] wp_q;
  logic [WIDTH-1:0]      resRe   [NUM_MAC];
  logic [WIDTH-1:0]      resIm   [NUM_MAC];
  logic [WIDTH-1:0]      outRe_q [NUM_MAC];
  logic [WIDTH-1:0]      outIm_q [NUM_MAC];
  logic                  done_q;

  assign inRe = '{inaReal, inbReal, incReal, indReal};
  assign inIm = '{inaImag, inbImag, incImag, indImag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    latch   = 1'b0;
    accEn   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          lane_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        accEn  = 1'b1;
        lane_d = lane_q + LANE_W'(1);
        if (lane_q == LANE_W'(LANES - 1)) state_d = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are frozen at the start edge so later input changes are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        xRe_q[k] <= '0;
        xIm_q[k] <= '0;
      end
      for (int r = 0; r < NUM_REF; r++) addr_q[r] <= '0;
    end else if (latch) begin
      xRe_q  <= inRe;
      xIm_q  <= inIm;
      addr_q <= '{readAddr, readAddrReal, readAddrImag};
    end
  end

  // History is written only after the comparison so wp's slot reads old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int k = 0; k < LANES; k++) begin
          memRe_q[s][k] <= '0;
          memIm_q[s][k] <= '0;
        end
      end
      wp_q <= '0;
    end else if (commit) begin
      for (int k = 0; k < LANES; k++) begin
        memRe_q[wp_q][k] <= xRe_q[k];
        memIm_q[wp_q][k] <= xIm_q[k];
      end
      wp_q <= wp_q + ADDR_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NUM_MAC; i++) begin : g_mac
    logic [WIDTH-1:0] mRe, mIm;
    if (i < NUM_REF) begin : g_hist
      assign mRe = memRe_q[addr_q[i]][lane_q];
      assign mIm = memIm_q[addr_q[i]][lane_q];
    end else begin : g_energy
      assign mRe = xRe_q[lane_q];
      assign mIm = xIm_q[lane_q];
    end
    cmac_conj #(.WIDTH(WIDTH)) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (latch),
      .en_i    (accEn),
      .xRe_i   (xRe_q[lane_q]),
      .xIm_i   (xIm_q[lane_q]),
      .mRe_i   (mRe),
      .mIm_i   (mIm),
      .resRe_o (resRe[i]),
      .resIm_o (resIm[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MAC; i++) begin
        outRe_q[i] <= '0;
        outIm_q[i] <= '0;
      end
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        outRe_q <= resRe;
        outIm_q <= resIm;
      end
    end
  end

  assign outaReal = outRe_q[0];
  assign outaImag = outIm_q[0];
  assign outbReal = outRe_q[1];
  assign outbImag = outIm_q[1];
  assign outcReal = outRe_q[2];
  assign outcImag = outIm_q[2];
  assign outdReal = outRe_q[3];
  assign outdImag = outIm_q[3];
  assign done     = done_q;

endmodule

// File: tb/tb_dot_product.sv
// Randomised self-checking bench for dot_product against an arithmetic
// reference model of the history ring and conjugate dot products.
module tb_dot_product;

  localparam int W     = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  inRe [4];
  logic [W-1:0]  inIm [4];
  logic [AW-1:0] readAddr, readAddrReal, readAddrImag;
  logic [W-1:0]  outRe [4];
  logic [W-1:0]  outIm [4];
  logic          done;

  int errors;
  int checks;
  int latency;

  int memR [DEPTH][4];
  int memI [DEPTH][4];
  int mwp;
  int xR [4];
  int xI [4];
  int addr [3];
  logic [W-1:0] expRe [4];
  logic [W-1:0] expIm [4];

  always #5 clk = ~clk;

  dot_product #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .inaReal      (inRe[0]),
    .inaImag      (inIm[0]),
    .inbReal      (inRe[1]),
    .inbImag      (inIm[1]),
    .incReal      (inRe[2]),
    .incImag      (inIm[2]),
    .indReal      (inRe[3]),
    .indImag      (inIm[3]),
    .readAddr     (readAddr),
    .readAddrReal (readAddrReal),
    .readAddrImag (readAddrImag),
    .outaReal     (outRe[0]),
    .outaImag     (outIm[0]),
    .outbReal     (outRe[1]),
    .outbImag     (outIm[1]),
    .outcReal     (outRe[2]),
    .outcImag     (outIm[2]),
    .outdReal     (outRe[3]),
    .outdImag     (outIm[3]),
    .done         (done)
  );

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic longint satf(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < DEPTH; s++) begin
      for (int k = 0; k < 4; k++) begin
        memR[s][k] = 0;
        memI[s][k] = 0;
      end
    end
    mwp = 0;
  endfunction

  // Expected results use the history as it was before this vector joins it.
  function automatic void modelOp();
    longint accR, accI;
    int mr, mi;
    for (int r = 0; r < 4; r++) begin
      accR = 0;
      accI = 0;
      for (int k = 0; k < 4; k++) begin
        if (r < 3) begin
          mr = memR[addr[r]][k];
          mi = memI[addr[r]][k];
        end else begin
          mr = xR[k];
          mi = xI[k];
        end
        accR += longint'(xR[k]) * mr + longint'(xI[k]) * mi;
        accI += longint'(xI[k]) * mr - longint'(xR[k]) * mi;
      end
      expRe[r] = 16'(satf(accR >>> 15));
      expIm[r] = 16'(satf(accI >>> 15));
    end
    for (int k = 0; k < 4; k++) begin
      memR[mwp][k] = xR[k];
      memI[mwp][k] = xI[k];
    end
    mwp = (mwp + 1) % DEPTH;
  endfunction

  function automatic void setZeroX();
    for (int k = 0; k < 4; k++) begin
      xR[k] = 0;
      xI[k] = 0;
    end
  endfunction

  function automatic void setRandomX();
    for (int k = 0; k < 4; k++) begin
      xR[k] = rnd16();
      xI[k] = rnd16();
    end
    for (int r = 0; r < 3; r++) addr[r] = int'($urandom_range(0, DEPTH - 1));
  endfunction

  // Runs one operation and scrambles the inputs right after the start edge.
  task automatic applyStimulus(input string name);
    int cycles;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      inRe[k] = 16'(xR[k]);
      inIm[k] = 16'(xI[k]);
    end
    readAddr     = 3'(addr[0]);
    readAddrReal = 3'(addr[1]);
    readAddrImag = 3'(addr[2]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inRe[k] = 16'($urandom);
      inIm[k] = 16'($urandom);
    end
    readAddr     = 3'($urandom);
    readAddrReal = 3'($urandom);
    readAddrImag = 3'($urandom);
    modelOp();
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    latency = cycles;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inRe[k] = '0;
      inIm[k] = '0;
    end
    readAddr = '0; readAddrReal = '0; readAddrImag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b, required 0", done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outRe[i] !== 16'h0 || outIm[i] !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_out%0d: got %h+j%h, required 0000+j0000", i, outRe[i], outIm[i]);
      end
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_first_ops();
    setZeroX();
    xR[0] = 16384;
    addr = '{0, 0, 0};
    applyStimulus("first_op");
    checks++;
    if (latency != 5) begin
      errors++;
      $display("[TB] FAIL first_latency: got %0d cycles, required 5", latency);
    end
    checks++;
    if ({outRe[3], outIm[3]} !== 32'h2000_0000) begin
      errors++;
      $display("[TB] FAIL first_energy: got %h+j%h, required 2000+j0000", outRe[3], outIm[3]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({outRe[i], outIm[i]} !== 32'h0) begin
        errors++;
        $display("[TB] FAIL first_out%0d: got %h+j%h, required 0000+j0000", i, outRe[i], outIm[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || outRe[3] !== 16'h2000) begin
      errors++;
      $display("[TB] FAIL done_pulse_hold: done=%b outd=%h, required done=0 outd=2000", done, outRe[3]);
    end
    applyStimulus("second_op");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({outRe[i], outIm[i]} !== 32'h2000_0000) begin
        errors++;
        $display("[TB] FAIL second_out%0d: got %h+j%h, required 2000+j0000", i, outRe[i], outIm[i]);
      end
    end
  endtask

  task automatic test_conjugate();
    int slot;
    setZeroX();
    xI[0] = 16384;
    addr = '{0, 1, 0};
    slot = mwp;
    applyStimulus("conj_store");
    setZeroX();
    xR[0] = 16384;
    addr = '{slot, 0, slot};
    applyStimulus("conj_read");
    checks++;
    if ({outRe[0], outIm[0]} !== 32'h0000_E000) begin
      errors++;
      $display("[TB] FAIL conj_outa: got %h+j%h, required 0000+jE000", outRe[0], outIm[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
        errors++;
        $display("[TB] FAIL conj_model_out%0d: got %h+j%h, required %h+j%h", i, outRe[i], outIm[i], expRe[i], expIm[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int slot;
    for (int k = 0; k < 4; k++) begin
      xR[k] = 32767;
      xI[k] = 32767;
    end
    addr = '{1, 2, 3};
    applyStimulus("sat_pos");
    checks++;
    if ({outRe[3], outIm[3]} !== 32'h7FFF_0000) begin
      errors++;
      $display("[TB] FAIL sat_pos_energy: got %h+j%h, required 7FFF+j0000", outRe[3], outIm[3]);
    end
    for (int k = 0; k < 4; k++) begin
      xR[k] = -32768;
      xI[k] = 0;
    end
    slot = mwp;
    applyStimulus("sat_store");
    for (int k = 0; k < 4; k++) xR[k] = 32767;
    addr = '{slot, slot, 0};
    applyStimulus("sat_neg");
    checks++;
    if (outRe[0] !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL sat_neg_outa: got %h, required 8000", outRe[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
        errors++;
        $display("[TB] FAIL sat_model_out%0d: got %h+j%h, required %h+j%h", i, outRe[i], outIm[i], expRe[i], expIm[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      setRandomX();
      applyStimulus("random");
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_out%0d: got %h+j%h, required %h+j%h", n, i, outRe[i], outIm[i], expRe[i], expIm[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int n = 0; n < 9; n++) begin
      setRandomX();
      xR[0] = n + 1;
      applyStimulus("wrap_fill");
    end
    setRandomX();
    addr[0] = 0;
    applyStimulus("wrap_read");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
        errors++;
        $display("[TB] FAIL wrap_out%0d: got %h+j%h, required %h+j%h", i, outRe[i], outIm[i], expRe[i], expIm[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int doneAt [3];
    int n;
    int cyc;
    setRandomX();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      inRe[k] = 16'(xR[k]);
      inIm[k] = 16'(xI[k]);
    end
    readAddr     = 3'(addr[0]);
    readAddrReal = 3'(addr[1]);
    readAddrImag = 3'(addr[2]);
    start = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        doneAt[n] = cyc;
        n++;
        if (n == 3) start = 1'b0;
        modelOp();
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
            errors++;
            $display("[TB] FAIL b2b%0d_out%0d: got %h+j%h, required %h+j%h", n, i, outRe[i], outIm[i], expRe[i], expIm[i]);
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d done pulses in %0d cycles, required 3", n, cyc);
    end else begin
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (doneAt[j] - doneAt[j-1] != 6) begin
          errors++;
          $display("[TB] FAIL b2b_period%0d: got %0d cycles, required 6", j, doneAt[j] - doneAt[j-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    setRandomX();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      inRe[k] = 16'(xR[k]);
      inIm[k] = 16'(xI[k]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL abort_done: got a done pulse, required none");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({outRe[i], outIm[i]} !== 32'h0) begin
        errors++;
        $display("[TB] FAIL abort_out%0d: got %h+j%h, required 0000+j0000", i, outRe[i], outIm[i]);
      end
    end
    modelReset();
    setRandomX();
    applyStimulus("after_abort");
    checks++;
    if (latency != 5) begin
      errors++;
      $display("[TB] FAIL after_abort_latency: got %0d cycles, required 5", latency);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outRe[i] !== expRe[i] || outIm[i] !== expIm[i]) begin
        errors++;
        $display("[TB] FAIL after_abort_out%0d: got %h+j%h, required %h+j%h", i, outRe[i], outIm[i], expRe[i], expIm[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    latency = 0;
    test_reset();
    test_first_ops();
    test_conjugate();
    test_saturation();
    test_random();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
